// File: rtl/dice_roll_ctrl.sv
// Dice roller: edge-detected die buttons start a spin/settle animation on a BCD counter.
// Optional result history (prev_bcd) is built only when DICE_HISTORY_EN is defined.
module dice_roll_ctrl #(
  parameter int SPIN_TICKS   = 16,
  parameter int SETTLE_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] req,
  output logic [7:0] value_bcd,
  output logic [2:0] die_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] prev_bcd
);

  localparam int TW = $clog2(SPIN_TICKS + 1);
  localparam int SW = $clog2(SETTLE_STEPS + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SPIN   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]    r_state;
  logic [6:0]    r_req_q;
  logic [7:0]    r_cnt;
  logic [7:0]    r_value;
  logic [2:0]    r_die;
  logic          r_done;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_step;
  logic [SW-1:0] r_wait;

  logic [6:0] w_edge;
  logic [2:0] w_sel;
  logic       w_any;
  logic [7:0] w_start;
  logic       w_spin_end;
  logic       w_step_end;
  logic       w_to_hold;

  function automatic logic [7:0] die_max(input logic [2:0] d);
    case (d)
      3'd0:    return 8'h04;
      3'd1:    return 8'h06;
      3'd2:    return 8'h08;
      3'd3:    return 8'h10;
      3'd4:    return 8'h12;
      3'd5:    return 8'h20;
      default: return 8'h99;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [2:0] d);
    if (v == die_max(d)) return (d == 3'd6) ? 8'h00 : 8'h01;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_edge = req & ~r_req_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_sel = 3'd0;
    w_any = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (w_edge[i]) begin
        w_sel = 3'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_start    = (w_sel == 3'd6) ? 8'h00 : 8'h01;
  assign w_spin_end = (r_state == S_SPIN) && tick && (r_tick_cnt == TW'(SPIN_TICKS - 1));
  assign w_step_end = (r_state == S_SETTLE) && tick && (r_wait == r_step + SW'(1));
  assign w_to_hold  = w_step_end && (r_step == SW'(SETTLE_STEPS - 1));

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_q    <= '0;
      r_cnt      <= 8'h01;
      r_value    <= 8'h01;
      r_die      <= 3'd0;
      r_done     <= 1'b0;
      r_tick_cnt <= '0;
      r_step     <= '0;
      r_wait     <= '0;
    end else begin
      r_req_q <= req;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_any) begin
            r_die      <= w_sel;
            r_cnt      <= w_start;
            r_value    <= w_start;
            r_tick_cnt <= '0;
            r_state    <= S_SPIN;
          end
        end
        S_SPIN: begin
          r_cnt <= bcd_inc(r_cnt, r_die);
          if (tick) begin
            r_value    <= r_cnt;
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
          if (w_spin_end) begin
            r_tick_cnt <= '0;
            r_step     <= '0;
            r_wait     <= '0;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= bcd_inc(r_cnt, r_die);
          if (w_step_end) begin
            r_value <= r_cnt;
            r_wait  <= '0;
            r_step  <= r_step + SW'(1);
          end else if (tick) begin
            r_wait <= r_wait + SW'(1);
          end
          if (w_to_hold) begin
            r_done  <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign value_bcd = r_value;
  assign die_sel   = r_die;
  assign done      = r_done;
  assign busy      = (r_state == S_SPIN) || (r_state == S_SETTLE);

`ifdef DICE_HISTORY_EN
  // value_bcd is reloaded at acceptance, so the last final result is kept on its own.
  logic [7:0] r_prev;
  logic [7:0] r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 8'h00;
      r_last <= 8'h01;
    end else if (w_to_hold) begin
      r_prev <= r_last;
      r_last <= r_cnt;
    end
  end

  assign prev_bcd = r_prev;
`else
  assign prev_bcd = 8'h00;
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl: a small-parameter instance for most cases
// plus a default-parameter instance for full spin/settle timing.
module tb_dice_roll_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [6:0] req;

  logic [7:0] value_bcd, prev_bcd, d_value, d_prev;
  logic [2:0] die_sel, d_die;
  logic       busy, done, d_busy, d_done;

  int n_vec = 0;
  int n_bad = 0;

  // results of the most recent run()
  int n_done, done_at, ticks_before_done, busy_rises, illegal_cnt;
  logic [7:0] hist_last;

  dice_roll_ctrl #(.SPIN_TICKS(2), .SETTLE_STEPS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req),
    .value_bcd(value_bcd), .die_sel(die_sel), .busy(busy), .done(done), .prev_bcd(prev_bcd)
  );

  dice_roll_ctrl dut_d (
    .clk(clk), .rst(rst), .tick(tick), .req(req),
    .value_bcd(d_value), .die_sel(d_die), .busy(d_busy), .done(d_done), .prev_bcd(d_prev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic bit legal(input logic [2:0] d, input logic [7:0] v);
    int n;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 1'b0;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    case (d)
      3'd0:    return n >= 1 && n <= 4;
      3'd1:    return n >= 1 && n <= 6;
      3'd2:    return n >= 1 && n <= 8;
      3'd3:    return n >= 1 && n <= 10;
      3'd4:    return n >= 1 && n <= 12;
      3'd5:    return n >= 1 && n <= 20;
      default: return 1'b1;
    endcase
  endfunction

  // One clock with the given tick; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Cycle k (1-based, k=1 is the first cycle after acceptance) carries a tick when
  // k = t_first + j*t_every for j < t_count; req switches to press_val at k == press_k.
  task automatic run(input bit use_d, input int ncyc, input int t_first, input int t_every,
                     input int t_count, input int press_k, input logic [6:0] press_val);
    int   ticks;
    logic b_prev, b_now, d_now, t;
    logic [7:0] v_now;
    logic [2:0] s_now;
    n_done = 0; done_at = -1; ticks_before_done = -1; busy_rises = 0; illegal_cnt = 0;
    ticks  = 0;
    b_prev = use_d ? d_busy : busy;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == press_k) req = press_val;
      t = (k >= t_first) && ((k - t_first) % t_every == 0) && ((k - t_first) / t_every < t_count);
      if (t) ticks++;
      cyc(t);
      b_now = use_d ? d_busy  : busy;
      d_now = use_d ? d_done  : done;
      v_now = use_d ? d_value : value_bcd;
      s_now = use_d ? d_die   : die_sel;
      if (!b_prev && b_now) busy_rises++;
      b_prev = b_now;
      if (!legal(s_now, v_now)) illegal_cnt++;
      if (d_now) begin
        if (n_done == 0) begin
          done_at = k + 1;
          ticks_before_done = ticks;
        end
        n_done++;
      end
    end
  endtask

  task automatic roll_checks(input string tag, input bit use_d, input logic [7:0] exp_val,
                             input int exp_done_at, input int exp_ticks);
    logic [7:0] exp_prev;
`ifdef DICE_HISTORY_EN
    exp_prev  = hist_last;
    hist_last = exp_val;
`else
    exp_prev  = 8'h00;
`endif
    check({tag, " done_cnt"},   32'(n_done), 1);
    check({tag, " done_at"},    32'(done_at), 32'(exp_done_at));
    check({tag, " done_ticks"}, 32'(ticks_before_done), 32'(exp_ticks));
    check({tag, " result"},     32'(use_d ? d_value : value_bcd), 32'(exp_val));
    check({tag, " busy_end"},   32'(use_d ? d_busy : busy), 0);
    check({tag, " illegal"},    32'(illegal_cnt), 0);
    check({tag, " prev_bcd"},   32'(use_d ? d_prev : prev_bcd), 32'(exp_prev));
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; req = 7'd0;
    hist_last = 8'h01;

    // reset state
    cyc(0); cyc(0);
    check("rst value", 32'(value_bcd), 32'h01);
    check("rst die",   32'(die_sel), 0);
    check("rst busy",  32'(busy), 0);
    check("rst done",  32'(done), 0);
    check("rst prev",  32'(prev_bcd), 32'h00);
    check("rst state", 32'(dut.r_state), 0);
    check("rst cnt",   32'(dut.r_cnt), 32'h01);
    rst = 1'b0;
    cyc(1);
    check("idle tick ignored", 32'(busy), 0);

    // priority: d6-index 2 (d8) beats bit 5 (d20)
    req = 7'b0100100;
    cyc(0);
    check("prio die",  32'(die_sel), 2);
    check("prio busy", 32'(busy), 1);
    check("prio start", 32'(dut.r_cnt), 32'h01);

    // reset mid-SETTLE
    cyc(1); cyc(1);
    check("settle reached", 32'(dut.r_state), 2);
    rst = 1'b1;
    cyc(1);
    check("midrst busy",  32'(busy), 0);
    check("midrst done",  32'(done), 0);
    check("midrst value", 32'(value_bcd), 32'h01);
    check("midrst die",   32'(die_sel), 0);
    check("midrst state", 32'(dut.r_state), 0);

    // level held through reset is a rising edge on the first cycle after
    rst = 1'b0;
    cyc(0);
    check("post-rst edge die",  32'(die_sel), 2);
    check("post-rst edge busy", 32'(busy), 1);
    rst = 1'b1; req = 7'd0;
    cyc(0);
    rst = 1'b0;
    cyc(0);
    hist_last = 8'h01;

    // d6 with d20 pressed mid-SPIN; ticks at cycles 3,6,9,12 -> result 06
    req = 7'b0000010;
    cyc(0);
    check("d6 accept die", 32'(die_sel), 1);
    run(1'b0, 20, 3, 3, 4, 2, 7'b0100010);
    check("d6 die kept", 32'(die_sel), 1);
    check("d6 no rebusy", 32'(busy_rises), 0);
    roll_checks("d6", 1'b0, 8'h06, 13, 4);

    // held req[0] across a whole roll: exactly one roll, result 04
    req = 7'd0;
    cyc(0); cyc(0);
    req = 7'b0000001;
    cyc(0);
    run(1'b0, 24, 1, 1, 24, 0, 7'd0);
    check("hold no rebusy", 32'(busy_rises), 0);
    roll_checks("retrig", 1'b0, 8'h04, 5, 4);

    // d4 wrap with ticks suppressed for 9 cycles
    req = 7'd0;
    cyc(0);
    req = 7'b0000001;
    cyc(0);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("d4 cnt k%0d", k), 32'(dut.r_cnt), 32'(to_bcd((k - 1) % 4 + 1)));
      cyc(0);
    end
    run(1'b0, 8, 1, 1, 4, 0, 7'd0);
    roll_checks("d4 wrap", 1'b0, 8'h01, 5, 4);

    // d100 counts 00..99 and wraps 99->00
    req = 7'd0;
    cyc(0);
    req = 7'b1000000;
    cyc(0);
    check("d100 start value", 32'(value_bcd), 32'h00);
    for (int k = 1; k <= 105; k++) begin
      check($sformatf("d100 cnt k%0d", k), 32'(dut.r_cnt), 32'(to_bcd((k - 1) % 100)));
      cyc(0);
    end
    run(1'b0, 8, 1, 1, 4, 0, 7'd0);
    roll_checks("d100", 1'b0, 8'h08, 5, 4);

    // default parameters: 16 spin ticks + 2+3+4+5 settle ticks
    rst = 1'b1; req = 7'd0;
    cyc(0);
    rst = 1'b0;
    cyc(0);
    hist_last = 8'h01;
    req = 7'b0000001;
    cyc(0);
    check("def accept busy", 32'(d_busy), 1);
    run(1'b1, 40, 1, 1, 40, 0, 7'd0);
    check("def die", 32'(d_die), 0);
    roll_checks("default", 1'b1, 8'h02, 31, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
